// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser deserialiser.
// Optional parity frame support is selected with the SIPO_PARITY_EN macro.
package sipo_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Counter width able to hold the value w.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

`ifdef SIPO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit counter for one serial frame.
// The frame is WIDTH data bits plus the optional parity bit (SIPO_PARITY_EN).
// word is the complete frame including the bit being sampled; it is only
// meaningful while word_done is high.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = cnt_width(WIDTH + PARITY_BITS),
  localparam int FRAME_W  = WIDTH + PARITY_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               clr,
  output logic [FRAME_W-1:0] word,
  output logic               word_done,
  output logic [CNT_W-1:0]   bit_cnt
);

  logic [FRAME_W-1:0] sh_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [FRAME_W-1:0] shifted;
  logic               last_bit;

  assign last_bit = (cnt_q == CNT_W'(FRAME_W - 1));

  // New bit enters the LSB when MSB-first, the MSB when LSB-first.
  always_comb begin
    shifted = '0;
    if (MSB_FIRST) shifted = {sh_q[FRAME_W-2:0], din};
    else           shifted = {din, sh_q[FRAME_W-1:1]};
  end

  assign word      = shifted;
  assign word_done = en && !clr && last_bit;
  assign bit_cnt   = cnt_q;

  // Accumulate bits; restart the frame on clr or after the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (en) begin
      if (last_bit) begin
        sh_q  <= '0;
        cnt_q <= '0;
      end else begin
        sh_q  <= shifted;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-to-parallel deserialiser with valid/ready output,
// selectable bit order, synchronous frame restart and sticky overrun.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame and
// expose parity_err alongside dout.
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no unconsumed word, dout_valid=0
// ST_FULL  | dout holds a word awaiting dout_ready
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = cnt_width(WIDTH + PARITY_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
`ifdef SIPO_PARITY_EN
  ,
  output logic             parity_err
`endif
);

  localparam int FRAME_W = WIDTH + PARITY_BITS;

  out_state_t         state;
  logic [FRAME_W-1:0] word;
  logic               word_done;
  logic [WIDTH-1:0]   word_data;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CNT_W     (CNT_W)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .din       (din),
    .clr       (clr),
    .word      (word),
    .word_done (word_done),
    .bit_cnt   (bit_cnt)
  );

  // The parity bit is always the last one received, so it sits at the
  // LSB end when MSB-first and at the MSB end when LSB-first.
  assign word_data = MSB_FIRST ? word[FRAME_W-1 -: WIDTH] : word[WIDTH-1:0];

`ifdef SIPO_PARITY_EN
  logic word_par_err;
  // Even parity over data plus parity bit: any odd count is an error.
  assign word_par_err = ^word;
`endif

  assign dout_valid = (state == ST_FULL);

  // Output holding register, handshake FSM and sticky overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_EMPTY;
      dout       <= '0;
      overrun    <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (clr) overrun <= 1'b0;
      case (state)
        ST_EMPTY: begin
          if (word_done) begin
            dout  <= word_data;
            state <= ST_FULL;
`ifdef SIPO_PARITY_EN
            parity_err <= word_par_err;
`endif
          end
        end
        ST_FULL: begin
          if (word_done) begin
            if (dout_ready) begin
              dout <= word_data;
`ifdef SIPO_PARITY_EN
              parity_err <= word_par_err;
`endif
            end else begin
              // word_done implies clr=0, so this cannot fight the clear above.
              overrun <= 1'b1;
            end
          end else if (dout_ready) begin
            state <= ST_EMPTY;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed self-checking bench for sipo_deser (WIDTH=8).
// Two instances share all stimulus: one MSB-first, one LSB-first.
module tb_sipo_deser;
  import sipo_pkg::*;

  localparam int CW = cnt_width(8 + PARITY_BITS);

  logic          clk;
  logic          rst;
  logic          en;
  logic          din;
  logic          clr;
  logic          ready;
  logic [7:0]    dout_m, dout_l;
  logic          valid_m, valid_l;
  logic [CW-1:0] cnt_m, cnt_l;
  logic          ovr_m, ovr_l;
`ifdef SIPO_PARITY_EN
  logic          perr_m, perr_l;
`endif

  int errors = 0;
  int checks = 0;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .clr        (clr),
    .dout       (dout_m),
    .dout_valid (valid_m),
    .dout_ready (ready),
    .bit_cnt    (cnt_m),
    .overrun    (ovr_m)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (perr_m)
`endif
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .clr        (clr),
    .dout       (dout_l),
    .dout_valid (valid_l),
    .dout_ready (ready),
    .bit_cnt    (cnt_l),
    .overrun    (ovr_l)
`ifdef SIPO_PARITY_EN
    ,
    .parity_err (perr_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  // One strobed bit; returns 1 time unit after the sampling edge.
  task automatic send_bit(input logic b);
    en  = 1'b1;
    din = b;
    @(posedge clk);
    #1;
    en  = 1'b0;
    din = 1'b0;
  endtask

  // Sends w first bit = w[7]; adds a correct parity bit in the parity build.
  // When ready_last is set, dout_ready rises for the final bit's cycle.
  task automatic send_word(input logic [7:0] w, input bit ready_last);
    for (int i = 7; i >= 0; i--) begin
      if (ready_last && i == 0 && PARITY_BITS == 0) ready = 1'b1;
      send_bit(w[i]);
    end
`ifdef SIPO_PARITY_EN
    if (ready_last) ready = 1'b1;
    send_bit(^w);
`endif
  endtask

  initial begin
    logic [7:0] w;
    rst   = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    #1;
    check("rst_dout", {56'h0, dout_m}, 64'h0);
    check("rst_valid", {63'h0, valid_m}, 64'h0);
    check("rst_cnt", 64'(cnt_m), 64'h0);
    check("rst_ovr", {63'h0, ovr_m}, 64'h0);
    check("rst_valid_lsb", {63'h0, valid_l}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // A5 with the consumer always ready.
    ready = 1'b1;
    send_word(8'hA5, 1'b0);
    check("t1_dout_msb", {56'h0, dout_m}, 64'hA5);
    check("t1_dout_lsb", {56'h0, dout_l}, 64'hA5);
    check("t1_valid", {63'h0, valid_m}, 64'h1);
    check("t1_cnt_wrap", 64'(cnt_m), 64'h0);
    @(posedge clk);
    #1;
    check("t1_valid_drop", {63'h0, valid_m}, 64'h0);
    check("t1_dout_hold", {56'h0, dout_m}, 64'hA5);

    // Non-palindrome distinguishes the bit orders.
    send_word(8'hC0, 1'b0);
    check("t2_dout_msb", {56'h0, dout_m}, 64'hC0);
    check("t2_dout_lsb", {56'h0, dout_l}, 64'h03);
    @(posedge clk);
    #1;

    // Overrun: consumer stalled across two words.
    ready = 1'b0;
    send_word(8'h3C, 1'b0);
    check("t3_valid", {63'h0, valid_m}, 64'h1);
    check("t3_ovr_first", {63'h0, ovr_m}, 64'h0);
    send_word(8'hFF, 1'b0);
    check("t3_dout_kept", {56'h0, dout_m}, 64'h3C);
    check("t3_ovr_msb", {63'h0, ovr_m}, 64'h1);
    check("t3_ovr_lsb", {63'h0, ovr_l}, 64'h1);
    @(posedge clk);
    #1;
    check("t3_ovr_sticky", {63'h0, ovr_m}, 64'h1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("t3_ovr_clr", {63'h0, ovr_m}, 64'h0);
    check("t3_valid_after_clr", {63'h0, valid_m}, 64'h1);
    check("t3_dout_after_clr", {56'h0, dout_m}, 64'h3C);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_consumed", {63'h0, valid_m}, 64'h0);

    // Back-to-back words, ready only on word 2 completion cycle.
    ready = 1'b0;
    send_word(8'h5A, 1'b0);
    send_word(8'h96, 1'b1);
    check("t4_dout_msb", {56'h0, dout_m}, 64'h96);
    check("t4_dout_lsb", {56'h0, dout_l}, 64'h69);
    check("t4_valid", {63'h0, valid_m}, 64'h1);
    check("t4_ovr", {63'h0, ovr_m}, 64'h0);
    @(posedge clk);
    #1;
    check("t4_valid_drop", {63'h0, valid_m}, 64'h0);

    // en=0 holds the count even with din toggling.
    w = 8'hD3;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("hold_cnt_before", 64'(cnt_m), 64'h3);
    din = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    din = 1'b0;
    check("hold_cnt_after", 64'(cnt_m), 64'h3);
    check("hold_valid", {63'h0, valid_m}, 64'h0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
`ifdef SIPO_PARITY_EN
    send_bit(^w);
`endif
    check("hold_dout", {56'h0, dout_m}, 64'hD3);
    @(posedge clk);
    #1;

    // Async reset mid-frame.
    repeat (5) send_bit(1'b1);
    check("t5_cnt5", 64'(cnt_m), 64'h5);
    #2;
    rst = 1'b0;
    #1;
    check("t5_async_cnt", 64'(cnt_m), 64'h0);
    check("t5_async_dout", {56'h0, dout_m}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    send_word(8'h81, 1'b0);
    check("t5_dout_81", {56'h0, dout_m}, 64'h81);
    check("t5_valid_81", {63'h0, valid_m}, 64'h1);
    @(posedge clk);
    #1;

    // clr with en discards the partial frame and that bit.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    en  = 1'b1;
    din = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    clr = 1'b0;
    din = 1'b0;
    check("t5_clr_cnt", 64'(cnt_m), 64'h0);
    check("t5_clr_valid", {63'h0, valid_m}, 64'h0);
    send_word(8'h4C, 1'b0);
    check("t5_clr_dout_msb", {56'h0, dout_m}, 64'h4C);
    check("t5_clr_dout_lsb", {56'h0, dout_l}, {56'h0, rev8(8'h4C)});
    @(posedge clk);
    #1;

`ifdef SIPO_PARITY_EN
    // 8'h07 with correct then wrong parity.
    w = 8'h07;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    check("par_valid_8th", {63'h0, valid_m}, 64'h0);
    check("par_cnt_8", 64'(cnt_m), 64'h8);
    send_bit(1'b1);
    check("par_valid_9th", {63'h0, valid_m}, 64'h1);
    check("par_dout", {56'h0, dout_m}, 64'h07);
    check("par_dout_lsb", {56'h0, dout_l}, 64'hE0);
    check("par_ok", {63'h0, perr_m}, 64'h0);
    @(posedge clk);
    #1;
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
    send_bit(1'b0);
    check("par_err_msb", {63'h0, perr_m}, 64'h1);
    check("par_err_lsb", {63'h0, perr_l}, 64'h1);
    @(posedge clk);
    #1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
